// File: rtl/seq_divide_pkg.sv
// -----------------------------------------------------------------------------
// seq_divide_pkg
// Shared types and helpers for the sequential restoring divider.
//   div_state_t    : controller states (IDLE, CALC, DONE)
//   DIV_DEFAULT_W  : default operand width
//   div_cnt_width  : width of the iteration counter (must hold WIDTH-1)
// -----------------------------------------------------------------------------
package seq_divide_pkg;

  localparam int DIV_DEFAULT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // clog2(WIDTH) holds WIDTH-1 for every legal width; floor at 1 bit.
  function automatic int div_cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_divide_operation_step.sv
// -----------------------------------------------------------------------------
// div_restore_step
// One combinational iteration of restoring division.
//   rem_i      : current partial remainder (always < divisor_i)
//   divisor_i  : divisor
//   bit_i      : next dividend bit shifted into the remainder
//   rem_o      : partial remainder after the trial subtract / restore
//   q_bit_o    : quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_restore_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    shifted = {rem_i, bit_i};
    // Extra top bit acts as the borrow of the trial subtract.
    trial   = {1'b0, shifted} - {2'b00, divisor_i};
    // A non-negative trial is below divisor_i and so fits in WIDTH bits;
    // either of the two top bits set means the subtract went negative.
    q_bit_o = ~|trial[WIDTH+1:WIDTH];
    rem_o   = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divide_operation.sv
// -----------------------------------------------------------------------------
// seq_divide_operation
// Multi-cycle restoring divider, one quotient bit per clock, with a
// start/busy/done handshake. Divide by zero completes in one cycle with
// quotient = all ones, remainder = dividend and div_by_zero set.
//
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   start           : request, honoured only in IDLE or DONE
//   is_signed       : (SEQ_DIVIDE_SIGNED_EN only) two's-complement operands
//   dividend/divisor: operands, captured on an accepted start
//   busy            : high while iterating (CALC)
//   done            : one-cycle pulse, results valid that cycle
//   quotient/remainder/div_by_zero : last result, held until the next result
//
// Build option: define SEQ_DIVIDE_SIGNED_EN to add signed division
// (magnitude divide, sign fix-up applied on entry to DONE).
// -----------------------------------------------------------------------------
module seq_divide_operation
  import seq_divide_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SEQ_DIVIDE_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CNT_W    = div_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t       state_q;
  logic [WIDTH-1:0] rem_q;        // partial remainder
  logic [WIDTH-1:0] q_sr_q;       // dividend bits out, quotient bits in
  logic [WIDTH-1:0] divisor_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic [WIDTH-1:0] dividend_mag_d;
  logic [WIDTH-1:0] divisor_mag_d;
  logic [WIDTH-1:0] step_rem_d;
  logic             step_q_bit_d;
  logic [WIDTH-1:0] quotient_d;
  logic [WIDTH-1:0] remainder_d;

`ifdef SEQ_DIVIDE_SIGNED_EN
  logic q_neg_q, r_neg_q;
  logic q_neg_d, r_neg_d;
`endif

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .divisor_i (divisor_q),
    .bit_i     (q_sr_q[WIDTH-1]),
    .rem_o     (step_rem_d),
    .q_bit_o   (step_q_bit_d)
  );

  // Operand conditioning: the core always divides magnitudes.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    dividend_mag_d = dividend;
    divisor_mag_d  = divisor;
`ifdef SEQ_DIVIDE_SIGNED_EN
    q_neg_d = 1'b0;
    r_neg_d = 1'b0;
    if (is_signed) begin
      // Remainder follows the dividend; quotient sign is the XOR of both.
      r_neg_d = dividend[WIDTH-1];
      q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      // Negating the most-negative value yields its own bit pattern, which
      // is the correct unsigned magnitude.
      if (dividend[WIDTH-1]) dividend_mag_d = -dividend;
      if (divisor[WIDTH-1])  divisor_mag_d  = -divisor;
    end
`endif
  end

  // Final result as it will look on entry to DONE (last step folded in).
  always_comb begin
    quotient_d  = {q_sr_q[WIDTH-2:0], step_q_bit_d};
    remainder_d = step_rem_d;
`ifdef SEQ_DIVIDE_SIGNED_EN
    if (q_neg_q) quotient_d  = -quotient_d;
    if (r_neg_q) remainder_d = -remainder_d;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      q_sr_q      <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef SEQ_DIVIDE_SIGNED_EN
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (divisor != '0) begin
              rem_q     <= '0;
              q_sr_q    <= dividend_mag_d;
              divisor_q <= divisor_mag_d;
              cnt_q     <= CNT_LAST;
              dbz_q     <= 1'b0;
`ifdef SEQ_DIVIDE_SIGNED_EN
              q_neg_q   <= q_neg_d;
              r_neg_q   <= r_neg_d;
`endif
              state_q   <= CALC;
            end else begin
              // Zero divisor short-circuits straight to DONE.
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              state_q     <= DONE;
            end
          end else begin
            state_q <= IDLE;
          end
        end

        CALC: begin
          rem_q  <= step_rem_d;
          q_sr_q <= {q_sr_q[WIDTH-2:0], step_q_bit_d};
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            state_q     <= DONE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divide_operation.sv
// -----------------------------------------------------------------------------
// tb_seq_divide_operation
// Self-checking bench for seq_divide_operation (WIDTH=4). Expected results
// come from plain integer division in a reference function; handshake timing
// (latency, busy length, one-cycle done) comes from the protocol rules.
// -----------------------------------------------------------------------------
module tb_seq_divide_operation;

  localparam int W = 4;
`ifdef SEQ_DIVIDE_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
`ifdef SEQ_DIVIDE_SIGNED_EN
  logic         is_signed;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  // Result the outputs must keep showing until the next one lands.
  logic [W-1:0] held_q = '0;
  logic [W-1:0] held_r = '0;

  seq_divide_operation #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef SEQ_DIVIDE_SIGNED_EN
    .is_signed   (is_signed),
`endif
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer division; signed mode truncates toward zero and the
  // remainder takes the dividend's sign (SystemVerilog int semantics).
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int sa, sb, qi, ri;
    z = (b == '0);
    if (z) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      qi = sa / sb;
      ri = sa % sb;
      q  = W'(qi);
      r  = W'(ri);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic drive_noise();
    dividend = W'($urandom);
    divisor  = W'($urandom);
`ifdef SEQ_DIVIDE_SIGNED_EN
    is_signed = 1'($urandom);
`endif
  endtask

  // Called #1 after an edge with the DUT ready; returns #1 after the edge
  // on which done is first seen (the DONE cycle). noise: 0 none,
  // 1 random start pulses during CALC, 2 start pulse every CALC cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input int noise, input string tag);
    logic [W-1:0] eq, er;
    logic         ez;
    int           cycles, busy_cnt;
    model(a, b, s, eq, er, ez);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
`ifdef SEQ_DIVIDE_SIGNED_EN
    is_signed = s;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    drive_noise();
    cycles   = 1;
    busy_cnt = 0;
    while (!done && cycles < 20) begin
      if (busy) busy_cnt++;
      check({tag, "/held_q"}, 32'(quotient), 32'(held_q));
      check({tag, "/held_r"}, 32'(remainder), 32'(held_r));
      if (noise == 2 || (noise == 1 && $urandom_range(1, 0) == 1)) begin
        start = 1'b1;
        drive_noise();
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    check({tag, "/latency"}, 32'(cycles), ez ? 32'd1 : 32'(W + 1));
    check({tag, "/busy_cycles"}, 32'(busy_cnt), ez ? 32'd0 : 32'(W));
    check({tag, "/done"}, 32'(done), 32'd1);
    check({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "/quotient"}, 32'(quotient), 32'(eq));
    check({tag, "/remainder"}, 32'(remainder), 32'(er));
    check({tag, "/div_by_zero"}, 32'(div_by_zero), 32'(ez));
    held_q = eq;
    held_r = er;
  endtask

  // One cycle after DONE with no start: done must have dropped.
  task automatic idle(input string tag);
    @(posedge clk); #1;
    check({tag, "/done_pulse"}, 32'(done), 32'd0);
    check({tag, "/idle_busy"}, 32'(busy), 32'd0);
    check({tag, "/idle_held_q"}, 32'(quotient), 32'(held_q));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef SEQ_DIVIDE_SIGNED_EN
    is_signed = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/quotient", 32'(quotient), 32'd0);
    check("reset/remainder", 32'(remainder), 32'd0);
    check("reset/div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    do_op(4'd13, 4'd3, 1'b0, 0, "13/3");   idle("13/3");
    do_op(4'd7, 4'd0, 1'b0, 0, "7/0");     idle("7/0");
    do_op(4'd15, 4'd1, 1'b0, 0, "15/1");   idle("15/1");
    do_op(4'd2, 4'd5, 1'b0, 0, "2/5");     idle("2/5");
    do_op(4'd0, 4'd9, 1'b0, 0, "0/9");     idle("0/9");
    do_op(4'd15, 4'd15, 1'b0, 0, "15/15"); idle("15/15");

    // start pulses with other operands during CALC are ignored.
    do_op(4'd11, 4'd2, 1'b0, 2, "ignore"); idle("ignore");

    // Back-to-back: second start issued in the DONE cycle of the first.
    do_op(4'd13, 4'd3, 1'b0, 0, "b2b_a");
    do_op(4'd9, 4'd4, 1'b0, 0, "b2b_b");
    idle("b2b_b");

    // Asynchronous reset in the middle of CALC.
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("midrst/busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst/busy", 32'(busy), 32'd0);
    check("midrst/done", 32'(done), 32'd0);
    check("midrst/quotient", 32'(quotient), 32'd0);
    check("midrst/remainder", 32'(remainder), 32'd0);
    check("midrst/div_by_zero", 32'(div_by_zero), 32'd0);
    held_q = '0;
    held_r = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(4'd9, 4'd2, 1'b0, 0, "9/2"); idle("9/2");

`ifdef SEQ_DIVIDE_SIGNED_EN
    do_op(4'b1001, 4'd2, 1'b1, 0, "s-7/2");  idle("s-7/2");
    do_op(4'b1000, 4'b1111, 1'b1, 0, "s-8/-1"); idle("s-8/-1");
    do_op(4'd6, 4'b1110, 1'b1, 0, "s6/-2");  idle("s6/-2");
    do_op(4'b1011, 4'd0, 1'b1, 0, "s-5/0");  idle("s-5/0");
`endif

    // Exhaustive unsigned sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(W'(a), W'(b), 1'b0, 0, "sweep");
        idle("sweep");
      end
    end

    // Randomized traffic: random operands, signedness, CALC-time start
    // noise, back-to-back issue and idle gaps.
    repeat (300) begin
      ra = W'($urandom);
      rb = ($urandom_range(7, 0) == 0) ? '0 : W'($urandom);
      rs = SIGNED_EN & 1'($urandom);
      do_op(ra, rb, rs, 1, "rand");
      if ($urandom_range(3, 0) != 0) begin
        idle("rand");
        repeat ($urandom_range(2, 0)) begin
          @(posedge clk); #1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
